// File: rtl/gray_rx_if.sv
// Link bundle between the Gray-count synchroniser and gray_rx_decoder.
// master drives the sampled count; slave is the decoder.
interface gray_rx_if #(
  parameter int CBITS = 18,
  parameter int ERRW  = 8
);
  logic [CBITS-1:0] gray_in;
  logic             gray_vld;
  logic [CBITS-1:0] bin_cnt;
  logic             bin_vld;
  logic             sig;
  logic             step_err;
  logic [ERRW-1:0]  err_cnt;
  logic             locked;

  modport master (
    output gray_in, gray_vld,
    input  bin_cnt, bin_vld, sig,
    input  step_err, err_cnt, locked
  );

  modport slave (
    input  gray_in, gray_vld,
    output bin_cnt, bin_vld, sig,
    output step_err, err_cnt, locked
  );
endinterface

// File: rtl/gray_rx_decoder.sv
// Gray-count receiver: decodes, checks +1 steps, regenerates wrap pulse,
// counts step errors and re-locks after RELOCK good steps.
module gray_rx_decoder #(
  parameter int CBITS  = 18,
  parameter int ERRW   = 8,
  parameter int RELOCK = 2
) (
  input logic      clk,
  input logic      rst_n,
  gray_rx_if.slave bus
);

  localparam int GW = (RELOCK > 1) ? $clog2(RELOCK + 1) : 1;
  localparam logic [GW-1:0] RELOCK_G = GW'(RELOCK);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    RESYNC
  } state_e;

  state_e           state_q;
  logic [CBITS-1:0] bin_q;
  logic             bin_vld_q;
  logic             sig_q;
  logic             err_q;
  logic [ERRW-1:0]  err_cnt_q;
  logic             locked_q;
  logic [GW-1:0]    good_q;

  logic [CBITS-1:0] bin_d;
  logic [CBITS-1:0] nxt_d;
  logic             same_d;
  logic             step_d;
  logic             bad_d;

  // bin_q doubles as the previous accepted sample
  always_comb begin
    bin_d = '0;
    for (int i = 0; i < CBITS; i++) begin
      bin_d[i] = ^(bus.gray_in >> i);
    end
  end

  assign nxt_d  = bin_q + 1'b1;
  assign same_d = (bin_d == bin_q);
  assign step_d = (bin_d == nxt_d);
  assign bad_d  = !same_d && !step_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      bin_vld_q <= 1'b0;
      sig_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      locked_q  <= 1'b0;
      good_q    <= '0;
    end else begin
      bin_vld_q <= 1'b0;
      sig_q     <= 1'b0;
      err_q     <= 1'b0;
      if (bus.gray_vld) begin
        case (state_q)
          IDLE: begin
            bin_q     <= bin_d;
            bin_vld_q <= 1'b1;
            state_q   <= TRACK;
            locked_q  <= 1'b1;
          end
          TRACK: begin
            unique case (1'b1)
              same_d: ;
              step_d: begin
                bin_q     <= bin_d;
                bin_vld_q <= 1'b1;
                sig_q     <= (bin_d == '0);
              end
              bad_d: begin
                bin_q     <= bin_d;
                bin_vld_q <= 1'b1;
                err_q     <= 1'b1;
                if (err_cnt_q != '1) begin
                  err_cnt_q <= err_cnt_q + 1'b1;
                end
                good_q   <= '0;
                state_q  <= RESYNC;
                locked_q <= 1'b0;
              end
            endcase
          end
          RESYNC: begin
            unique case (1'b1)
              same_d: ;
              step_d: begin
                bin_q     <= bin_d;
                bin_vld_q <= 1'b1;
                if (good_q + 1'b1 == RELOCK_G) begin
                  good_q   <= '0;
                  state_q  <= TRACK;
                  locked_q <= 1'b1;
                end else begin
                  good_q <= good_q + 1'b1;
                end
              end
              bad_d: begin
                bin_q     <= bin_d;
                bin_vld_q <= 1'b1;
                err_q     <= 1'b1;
                if (err_cnt_q != '1) begin
                  err_cnt_q <= err_cnt_q + 1'b1;
                end
                good_q <= '0;
              end
            endcase
          end
          default: begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.bin_cnt  = bin_q;
  assign bus.bin_vld  = bin_vld_q;
  assign bus.sig      = sig_q;
  assign bus.step_err = err_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.locked   = locked_q;

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Directed + random bench for gray_rx_decoder (CBITS=4, ERRW=8,
// RELOCK=2) against a step-classification reference model.
module tb_gray_rx_decoder;

  localparam int CB = 4;
  localparam int EW = 8;
  localparam int RL = 2;
  localparam int MOD = 16;

  logic clk;
  logic rst_n;

  gray_rx_if #(.CBITS(CB), .ERRW(EW)) bus ();

  gray_rx_decoder #(
    .CBITS(CB), .ERRW(EW), .RELOCK(RL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int sig_seen;
  int err_seen;

  // reference model: 0 idle, 1 track, 2 resync
  int m_state;
  int m_prev;
  int m_good;
  int m_err;
  int e_vld;
  int e_sig;
  int e_err;

  function automatic logic [CB-1:0] enc(input int b);
    return CB'(b ^ (b >> 1));
  endfunction

  function automatic int dec(input logic [CB-1:0] g);
    for (int b = 0; b < MOD; b++) begin
      if (enc(b) == g) return b;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_prev = 0; m_good = 0; m_err = 0;
    e_vld = 0; e_sig = 0; e_err = 0;
  endtask

  task automatic bad_hit();
    e_err = 1;
    e_vld = 1;
    m_err = (m_err < 255) ? m_err + 1 : 255;
    m_good = 0;
  endtask

  task automatic model_step(input logic [CB-1:0] g, input logic v);
    int b;
    b = dec(g);
    e_vld = 0; e_sig = 0; e_err = 0;
    if (v) begin
      if (m_state == 0) begin
        m_prev = b; e_vld = 1; m_state = 1;
      end else if (b == m_prev) begin
      end else if (b == (m_prev + 1) % MOD) begin
        e_vld = 1;
        if (m_state == 1) begin
          e_sig = (b == 0);
        end else begin
          m_good++;
          if (m_good == RL) begin
            m_good = 0; m_state = 1;
          end
        end
        m_prev = b;
      end else begin
        bad_hit();
        m_prev = b;
        m_state = 2;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".bin_cnt"}, 32'(bus.bin_cnt), 32'(m_prev));
    chk({tag, ".bin_vld"}, 32'(bus.bin_vld), 32'(e_vld));
    chk({tag, ".sig"}, 32'(bus.sig), 32'(e_sig));
    chk({tag, ".step_err"}, 32'(bus.step_err), 32'(e_err));
    chk({tag, ".err_cnt"}, 32'(bus.err_cnt), 32'(m_err));
    chk({tag, ".locked"}, 32'(bus.locked), 32'(m_state == 1));
  endtask

  task automatic drive(input int b, input logic v, input string tag);
    @(negedge clk);
    bus.gray_in  = enc(b);
    bus.gray_vld = v;
    @(posedge clk);
    #1;
    model_step(enc(b), v);
    if (bus.sig === 1'b1) sig_seen++;
    if (bus.step_err === 1'b1) err_seen++;
    check_all(tag);
  endtask

  initial begin
    int r;
    int b;
    checks = 0; failures = 0;
    rst_n = 1'b0;
    bus.gray_in = '0;
    bus.gray_vld = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: full count with wrap
    sig_seen = 0; err_seen = 0;
    for (int i = 0; i <= MOD; i++) drive(i % MOD, 1'b1, "t1");
    chk("t1.sig_count", 32'(sig_seen), 32'd1);
    chk("t1.err_count", 32'(err_seen), 32'd0);

    // 2: hold at 4
    for (int i = 1; i <= 4; i++) drive(i, 1'b1, "t2.pre");
    err_seen = 0;
    for (int i = 0; i < 5; i++) drive(4, 1'b1, "t2.hold");
    chk("t2.err_count", 32'(err_seen), 32'd0);
    chk("t2.bin_cnt", 32'(bus.bin_cnt), 32'd4);

    // 3: skip 5->7 then relock via 8,9
    drive(5, 1'b1, "t3");
    drive(7, 1'b1, "t3.skip");
    chk("t3.err_cnt", 32'(bus.err_cnt), 32'd1);
    chk("t3.unlocked", 32'(bus.locked), 32'd0);
    drive(8, 1'b1, "t3");
    drive(9, 1'b1, "t3");
    chk("t3.relocked", 32'(bus.locked), 32'd1);
    // relock across a wrap: no sig
    for (int i = 10; i <= 13; i++) drive(i, 1'b1, "t3b");
    sig_seen = 0;
    drive(15, 1'b1, "t3b.skip");
    drive(0, 1'b1, "t3b.wrap");
    drive(1, 1'b1, "t3b");
    chk("t3b.no_sig", 32'(sig_seen), 32'd0);
    chk("t3b.relocked", 32'(bus.locked), 32'd1);

    // 4: backward step then SAME in RESYNC
    for (int i = 2; i <= 6; i++) drive(i, 1'b1, "t4.pre");
    drive(5, 1'b1, "t4.back");
    chk("t4.step_err", 32'(bus.step_err), 32'd1);
    err_seen = 0;
    for (int i = 0; i < 3; i++) drive(5, 1'b1, "t4.same");
    chk("t4.err_count", 32'(err_seen), 32'd0);
    drive(6, 1'b1, "t4"); drive(7, 1'b1, "t4");

    // 5: saturate the error counter
    err_seen = 0;
    for (int i = 0; i < 300; i++) drive((m_prev + 2) % MOD, 1'b1, "t5");
    chk("t5.err_cnt_sat", 32'(bus.err_cnt), 32'd255);
    chk("t5.err_pulses", 32'(err_seen), 32'd300);

    // 6: async reset between edges
    drive(m_prev, 1'b0, "t6.idle");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6.async");
    @(negedge clk);
    rst_n = 1'b1;
    drive(9, 1'b1, "t6.first");
    chk("t6.first_locked", 32'(bus.locked), 32'd1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(99);
      if (r < 60) b = (m_prev + 1) % MOD;
      else if (r < 75) b = m_prev;
      else b = $urandom_range(MOD - 1);
      drive(b, (r % 10) != 0, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
